// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA add/subtract sequencer.
package cla_pkg;
   localparam int unsigned SLICE_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;
endpackage

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry-lookahead slice; purely combinational.
module cla4_cin (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Carries expanded in lookahead form rather than rippled.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign sum   = p ^ c[3:0];
   assign c_out = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial add/subtract sequencer: one shared CLA slice stepped LSB to MSB,
// operands and result exchanged over valid/ready handshakes.
module cla_seq_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);
   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   cla_seq_state_t state_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             ovf_q;

   logic [SLICE_W-1:0] a_nib;
   logic [SLICE_W-1:0] b_nib;
   logic [SLICE_W-1:0] s_nib;
   logic               c_nib;
   logic               last;
   logic               ovf_nib;

   assign a_nib = a_q[idx_q*SLICE_W +: SLICE_W];
   assign b_nib = b_q[idx_q*SLICE_W +: SLICE_W];

   cla4_cin u_slice (
      .a     (a_nib),
      .b     (b_nib),
      .c_in  (carry_q),
      .sum   (s_nib),
      .c_out (c_nib)
   );

   assign last = (idx_q == IW'(NSLICE - 1));
   // Only meaningful on the last step, where s_nib[3] is the result MSB.
   assign ovf_nib = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[SLICE_W-1] != a_q[WIDTH-1]);

   always_comb begin
      sum_d = sum_q;
      sum_d[idx_q*SLICE_W +: SLICE_W] = s_nib;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_sub ? ~in_b : in_b;
                  carry_q <= in_sub;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= c_nib;
               if (last) begin
                  idx_q   <= '0;
                  cout_q  <= c_nib;
                  ovf_q   <= ovf_nib;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed checks of the 16-bit sequencer plus exhaustive 4-bit add/subtract.
module tb_cla_seq_adder;
   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf, busy;
   logic [15:0] in_a, in_b, out_sum;

   logic        in_valid4, in_ready4, in_sub4, out_valid4, out_ready4, out_cout4, out_ovf4, busy4;
   logic [3:0]  in_a4, in_b4, out_sum4;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
   );

   cla_seq_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4), .in_sub(in_sub4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
      .out_cout(out_cout4), .out_ovf(out_ovf4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one 16-bit operation, then check latency and results before releasing it.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] es, input logic ec, input logic eo,
                        input logic release_now);
      int cyc;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = ~a; in_b = ~b; in_sub = ~sub;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd4);
      check({tag, "_sum"},  32'(out_sum),  32'(es));
      check({tag, "_cout"}, 32'(out_cout), 32'(ec));
      check({tag, "_ovf"},  32'(out_ovf),  32'(eo));
      if (release_now) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int cyc;
      logic [15:0] held_sum;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
      in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_sub4 = 1'b0; out_ready4 = 1'b0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_cout",  32'(out_cout),  32'd0);
      check("rst_out_ovf",   32'(out_ovf),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
      do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      do_op("sub_5m7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
      do_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);

      // Backpressure: result must stay frozen while the consumer stalls.
      do_op("hold", 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);
      held_sum = out_sum;
      for (int i = 0; i < 6; i++) begin
         in_a = 16'(16'hA5A5 + i); in_b = 16'(16'h5A5A - i);
         @(posedge clk); #1;
         check("hold_sum",      32'(out_sum),   32'h1235);
         check("hold_cout",     32'(out_cout),  32'd0);
         check("hold_ovf",      32'(out_ovf),   32'd0);
         check("hold_valid",    32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready),  32'd0);
         check("hold_busy",     32'(busy),      32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_valid",    32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready),  32'd1);
      check("release_sum_kept", 32'(out_sum),   32'(held_sum));
      do_op("b2b_1", 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      do_op("b2b_2", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of RUN discards the operation.
      @(negedge clk);
      in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("midrun_busy",    32'(busy),    32'd1);
      check("midrun_partial", 32'(out_sum), 32'h00FF);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_sum",   32'(out_sum),   32'd0);
      check("arst_busy",  32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

      // Exhaustive 4-bit: behavioural model from signed/unsigned integer arithmetic.
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               int sa, sb, r, ur;
               logic [3:0] es;
               logic ec, eo;
               sa = (a > 7) ? a - 16 : a;
               sb = (b > 7) ? b - 16 : b;
               r  = (s == 1) ? sa - sb : sa + sb;
               ur = (s == 1) ? a - b : a + b;
               es = 4'(ur & 15);
               ec = (s == 1) ? (a >= b) : (a + b > 15);
               eo = (r > 7) || (r < -8);
               @(negedge clk);
               in_a4 = 4'(a); in_b4 = 4'(b); in_sub4 = (s == 1); in_valid4 = 1'b1;
               @(posedge clk); #1;
               in_valid4 = 1'b0;
               cyc = 0;
               while (!out_valid4 && cyc < 10) begin
                  @(posedge clk); #1;
                  cyc++;
               end
               check("w4_latency", 32'(cyc),       32'd1);
               check("w4_sum",     32'(out_sum4),  32'(es));
               check("w4_cout",    32'(out_cout4), 32'(ec));
               check("w4_ovf",     32'(out_ovf4),  32'(eo));
               out_ready4 = 1'b1;
               @(posedge clk); #1;
               out_ready4 = 1'b0;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
